// File: rtl/onehot_rr_arbiter_pkg.sv
// onehot_arb_pkg: shared sizes, FSM state type and round-robin pick helper
package onehot_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, BUSY} state_t;
  // Returns {found, idx}; lowest offset from ptr wins, so scan high-to-low and keep the last hit
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
    logic found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] k;
    found = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) begin
        found = 1'b1;
        idx = k;
      end
    end
    return {found, idx};
  endfunction
endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// onehot_rr_arbiter_if: request/grant bundle between requesters and the arbiter
interface onehot_rr_arbiter_if;
  import onehot_arb_pkg::*;
  logic en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic grant_valid;
  logic timeout;
  modport master (output en, req, input grant, grant_idx, grant_valid, timeout);
  modport slave (input en, req, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/onehot_rr_arbiter_dec3to8.sv
// onehot_dec3to8: combinational 3-to-8 one-hot decoder
module onehot_dec3to8 (
  input  logic [2:0] in,
  output logic [7:0] out
);
  assign out = 8'b1 << in;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: 8-way round-robin arbiter with one-hot grant and optional hold timeout
module onehot_rr_arbiter
  import onehot_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  onehot_rr_arbiter_if.slave bus
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  state_t state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic valid;
  logic timeout;
  logic [HW-1:0] hold_cnt;
  logic [IDX_W:0] pick;
  logic [N_REQ-1:0] dec_out;
  logic expire;
  assign pick = rr_pick(bus.req, ptr);
  assign expire = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (bus.en && pick[IDX_W]) begin
          idx <= pick[IDX_W-1:0];
          valid <= 1'b1;
          hold_cnt <= '0;
          state <= BUSY;
        end
        BUSY: if (!bus.req[idx] || expire) begin
          // release has priority: timeout only fires while the grantee still requests
          timeout <= bus.req[idx];
          ptr <= idx + 3'd1;
          idx <= '0;
          valid <= 1'b0;
          state <= IDLE;
        end else if (hold_cnt != '1) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  onehot_dec3to8 u_dec (.in(idx), .out(dec_out));
  assign bus.grant = valid ? dec_out : '0;
  assign bus.grant_idx = idx;
  assign bus.grant_valid = valid;
  assign bus.timeout = timeout;
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed self-checking bench, DUT built with MAX_HOLD=4
module tb_onehot_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  onehot_rr_arbiter_if bus();
  onehot_rr_arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
    chk({tag, ".grant"}, bus.grant, g);
    chk({tag, ".idx"}, {5'd0, bus.grant_idx}, {5'd0, i});
    chk({tag, ".valid"}, {7'd0, bus.grant_valid}, {7'd0, v});
    chk({tag, ".timeout"}, {7'd0, bus.timeout}, {7'd0, t});
  endtask
  initial begin
    logic [7:0] r;
    bus.en = 1'b1;
    bus.req = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.req = 8'h20;
    tick();
    chk_out("single", 8'h20, 3'd5, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_out("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.req = 8'h41;
    tick();
    chk_out("ptr6", 8'h40, 3'd6, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    bus.req = 8'h80;
    tick();
    chk_out("ptr7", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    bus.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      r = 8'h01 << (k % 8);
      chk_out($sformatf("rr%0d", k), r, 3'(k % 8), 1'b1, 1'b0);
      tick();
      chk($sformatf("rr%0d.h1", k), bus.grant, r);
      tick();
      chk($sformatf("rr%0d.h2", k), bus.grant, r);
      bus.req = 8'hFF & ~r;
      tick();
      chk_out($sformatf("rr%0d.gap", k), 8'h00, 3'd0, 1'b0, 1'b0);
      bus.req = (k == 8) ? 8'h00 : 8'hFF;
      tick();
    end
    bus.req = 8'h80;
    tick();
    chk("pre_to", bus.grant, 8'h80);
    bus.req = 8'h00;
    tick();
    bus.req = 8'h09;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_out($sformatf("to0_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
      tick();
    end
    chk_out("to0_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_out($sformatf("to3_c%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
      tick();
    end
    chk_out("to3_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_out("to_back0", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_out("to_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.req = 8'h02;
    tick();
    chk("race_g", bus.grant, 8'h02);
    tick();
    tick();
    tick();
    chk("race_h3", bus.grant, 8'h02);
    bus.req = 8'h00;
    tick();
    chk_out("race_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.en = 1'b0;
    bus.req = 8'h02;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("en0_c%0d", c), bus.grant, 8'h00);
    end
    bus.en = 1'b1;
    tick();
    chk_out("en1", 8'h02, 3'd1, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    chk("en_drop1", bus.grant, 8'h02);
    tick();
    chk("en_drop2", bus.grant, 8'h02);
    bus.req = 8'h00;
    bus.en = 1'b1;
    tick();
    chk("en_rel", bus.grant, 8'h00);
    bus.req = 8'h80;
    tick();
    chk("pre_rst", bus.grant, 8'h80);
    bus.req = 8'h81;
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
